// File: rtl/dma_pkg.sv
// Shared states and register field positions for the SD host DMA sequencer.
// DMA_BOUNDARY_EN adds the BND_WAIT state used for boundary interrupts.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        XFER      = 3'd1,
        WAIT_ACK  = 3'd2,
        BLOCK_END = 3'd3,
        GAP_STOP  = 3'd4,
        DONE      = 3'd5
`ifdef DMA_BOUNDARY_EN
        ,
        BND_WAIT  = 3'd6
`endif
    } dma_state_e;

    localparam logic [1:0] CMD_ABORT = 2'b11;

    localparam int TM_DMA_EN  = 0;
    localparam int TM_BCNT_EN = 1;
    localparam int TM_DIR     = 4;
    localparam int TM_MULTI   = 5;

    localparam int BGC_STOP = 0;
    localparam int BGC_CONT = 1;

    function automatic logic is_abort(input logic [1:0] cmd_type);
        return cmd_type == CMD_ABORT;
    endfunction

endpackage

// File: rtl/dma_xfer_counter.sv
// Byte and block bookkeeping for the DMA sequencer: beat sizing,
// remaining-byte count, block countdown and end-of-block/transfer flags.
module dma_xfer_counter
    import dma_pkg::*;
#(
    parameter int BPB  = 4,
    parameter int MB_W = $clog2(BPB) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [11:0]     bs_in,
    input  logic [15:0]     bc_in,
    input  logic            multi_in,
    input  logic            bcnt_en_in,
    input  logic            reload,
    input  logic            beat_done,
    input  logic            block_done,
    output logic [15:0]     blocks_left,
    output logic [MB_W-1:0] mem_bytes,
    output logic            last_beat,
    output logic            last_block,
    output logic            zero_len
);

    localparam logic [11:0]     BPB_12 = 12'(BPB);
    localparam logic [MB_W-1:0] BPB_MB = MB_W'(BPB);

    logic [11:0] bs_q;
    logic [11:0] bs_d;
    logic [11:0] byte_rem_q;
    logic [11:0] byte_rem_d;
    logic [15:0] blocks_q;
    logic [15:0] blocks_d;
    logic        counting_q;
    logic        counting_d;

    always_comb begin
        mem_bytes = BPB_MB;
        if (byte_rem_q < BPB_12) begin
            mem_bytes = byte_rem_q[MB_W-1:0];
        end
    end

    assign last_beat   = byte_rem_q <= BPB_12;
    assign last_block  = counting_q && (blocks_q <= 16'd1);
    assign blocks_left = blocks_q;

    // Evaluated on the Start cycle from the live register images.
    assign zero_len = (bs_in == 12'd0) ||
                      (multi_in && bcnt_en_in && (bc_in == 16'd0));

    always_comb begin
        bs_d       = bs_q;
        byte_rem_d = byte_rem_q;
        blocks_d   = blocks_q;
        counting_d = counting_q;
        if (load) begin
            bs_d       = bs_in;
            byte_rem_d = bs_in;
            counting_d = !multi_in || bcnt_en_in;
            blocks_d   = multi_in ? bc_in : 16'd1;
        end else begin
            if (beat_done) begin
                byte_rem_d = byte_rem_q - 12'(mem_bytes);
            end
            if (reload) begin
                byte_rem_d = bs_q;
            end
            // Infinite mode holds the count; counted modes stop at zero.
            if (block_done && counting_q && (blocks_q != 16'd0)) begin
                blocks_d = blocks_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bs_q       <= '0;
            byte_rem_q <= '0;
            blocks_q   <= '0;
            counting_q <= 1'b0;
        end else begin
            bs_q       <= bs_d;
            byte_rem_q <= byte_rem_d;
            blocks_q   <= blocks_d;
            counting_q <= counting_d;
        end
    end

endmodule

// File: rtl/dma_transfer_ctrl.sv
// SD host DAT-path DMA sequencer: block/beat movement, gap stop, abort.
// Define DMA_BOUNDARY_EN for the address-boundary interrupt and reload.
module dma_transfer_ctrl
    import dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
`ifdef DMA_BOUNDARY_EN
    ,
    parameter int BOUNDARY_BYTES = 4096
`endif
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Start,
    input  logic [ADDR_W-1:0]            System_Address,
    input  logic [15:0]                  Block_Size_Register,
    input  logic [15:0]                  Block_Count_Register,
    input  logic [15:0]                  Transfer_Mode_Register,
    input  logic [7:0]                   Block_Gap_Control_Register,
    input  logic [15:0]                  Command_Register,
    input  logic                         Fifo_Ready,
    output logic                         Mem_Req,
    input  logic                         Mem_Ack,
    output logic [ADDR_W-1:0]            Mem_Addr,
    output logic                         Mem_Write,
    output logic [$clog2(DATA_W/8):0]    Mem_Bytes,
    output logic [15:0]                  Blocks_Left,
    output logic                         Read_Transfer_Active,
    output logic                         Write_Transfer_Active,
    output logic                         Block_Gap_Event,
    output logic                         Transfer_Complete,
    output logic                         Aborted
`ifdef DMA_BOUNDARY_EN
    ,
    input  logic                         Addr_Load,
    output logic                         Dma_Int
`endif
);

    localparam int BPB  = DATA_W / 8;
    localparam int MB_W = $clog2(BPB) + 1;

    dma_state_e        state_q;
    dma_state_e        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              dir_q;
    logic              dir_d;
    logic              abort_q;
    logic              abort_d;

`ifdef DMA_BOUNDARY_EN
    dma_state_e        resume_q;
    dma_state_e        resume_d;
    logic              dma_int_q;
    logic              dma_int_d;
    logic              at_boundary;
`endif

    logic              cnt_load;
    logic              cnt_reload;
    logic              cnt_beat;
    logic              cnt_block;
    logic              last_beat;
    logic              last_block;
    logic              zero_len;
    logic [MB_W-1:0]   beat_bytes;
    logic [ADDR_W-1:0] next_addr;
    logic              abort_req;
    logic              gap_evt;
    logic              unused_bits;

    assign abort_req = is_abort(Command_Register[7:6]);
    assign next_addr = addr_q + ADDR_W'(BPB);

`ifdef DMA_BOUNDARY_EN
    assign at_boundary = (next_addr % ADDR_W'(BOUNDARY_BYTES)) == '0;
`endif

    assign unused_bits = ^{Block_Size_Register[15:12],
                           Transfer_Mode_Register[15:6],
                           Transfer_Mode_Register[3:2],
                           Block_Gap_Control_Register[7:2],
                           Command_Register[15:8],
                           Command_Register[5:0]};

    dma_xfer_counter #(
        .BPB  (BPB),
        .MB_W (MB_W)
    ) u_counter (
        .clk         (CLK),
        .rst         (RESET),
        .load        (cnt_load),
        .bs_in       (Block_Size_Register[11:0]),
        .bc_in       (Block_Count_Register),
        .multi_in    (Transfer_Mode_Register[TM_MULTI]),
        .bcnt_en_in  (Transfer_Mode_Register[TM_BCNT_EN]),
        .reload      (cnt_reload),
        .beat_done   (cnt_beat),
        .block_done  (cnt_block),
        .blocks_left (Blocks_Left),
        .mem_bytes   (beat_bytes),
        .last_beat   (last_beat),
        .last_block  (last_block),
        .zero_len    (zero_len)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        abort_d    = abort_q;
        cnt_load   = 1'b0;
        cnt_reload = 1'b0;
        cnt_beat   = 1'b0;
        cnt_block  = 1'b0;
        gap_evt    = 1'b0;
`ifdef DMA_BOUNDARY_EN
        resume_d   = resume_q;
        dma_int_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (Start && Transfer_Mode_Register[TM_DMA_EN]) begin
                    addr_d   = System_Address;
                    dir_d    = Transfer_Mode_Register[TM_DIR];
                    cnt_load = 1'b1;
                    state_d  = zero_len ? DONE : XFER;
                end
            end
            XFER: begin
                if (abort_req) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (Fifo_Ready) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An abort here is remembered until the beat is acknowledged.
                if (abort_req) begin
                    abort_d = 1'b1;
                end
                if (Mem_Ack) begin
                    addr_d   = next_addr;
                    cnt_beat = 1'b1;
                    if (abort_req || abort_q) begin
                        state_d = DONE;
                    end
`ifdef DMA_BOUNDARY_EN
                    else if (at_boundary && !(last_beat && last_block)) begin
                        state_d   = BND_WAIT;
                        resume_d  = last_beat ? BLOCK_END : XFER;
                        dma_int_d = 1'b1;
                    end
`endif
                    else if (last_beat) begin
                        state_d = BLOCK_END;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            BLOCK_END: begin
                if (abort_req) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_block = 1'b1;
                    if (last_block) begin
                        state_d = DONE;
                    end else if (Block_Gap_Control_Register[BGC_STOP]) begin
                        gap_evt = 1'b1;
                        state_d = GAP_STOP;
                    end else begin
                        cnt_reload = 1'b1;
                        state_d    = XFER;
                    end
                end
            end
            GAP_STOP: begin
                if (abort_req) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (Block_Gap_Control_Register[BGC_CONT]) begin
                    cnt_reload = 1'b1;
                    state_d    = XFER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef DMA_BOUNDARY_EN
            BND_WAIT: begin
                if (abort_req) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (Addr_Load) begin
                    addr_d  = System_Address;
                    state_d = resume_q;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dir_q     <= 1'b0;
            abort_q   <= 1'b0;
`ifdef DMA_BOUNDARY_EN
            resume_q  <= IDLE;
            dma_int_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dir_q     <= dir_d;
            abort_q   <= abort_d;
`ifdef DMA_BOUNDARY_EN
            resume_q  <= resume_d;
            dma_int_q <= dma_int_d;
`endif
        end
    end

    assign Mem_Req               = state_q == WAIT_ACK;
    assign Mem_Addr              = addr_q;
    assign Mem_Write             = dir_q;
    assign Mem_Bytes             = beat_bytes;
    assign Read_Transfer_Active  = (state_q != IDLE) && dir_q;
    assign Write_Transfer_Active = (state_q != IDLE) && !dir_q;
    assign Block_Gap_Event       = gap_evt;
    assign Transfer_Complete     = state_q == DONE;
    assign Aborted               = (state_q == DONE) && abort_q;

`ifdef DMA_BOUNDARY_EN
    assign Dma_Int = dma_int_q;
`endif

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Scoreboard bench for dma_transfer_ctrl: a transfer-level model queues
// expected beats and completions; a monitor checks them as they appear.
module tb_dma_transfer_ctrl;

    localparam int BPB = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [31:0] System_Address;
    logic [15:0] Block_Size_Register;
    logic [15:0] Block_Count_Register;
    logic [15:0] Transfer_Mode_Register;
    logic [7:0]  Block_Gap_Control_Register;
    logic [15:0] Command_Register;
    logic        Fifo_Ready;
    logic        Mem_Req;
    logic        Mem_Ack;
    logic [31:0] Mem_Addr;
    logic        Mem_Write;
    logic [2:0]  Mem_Bytes;
    logic [15:0] Blocks_Left;
    logic        Read_Transfer_Active;
    logic        Write_Transfer_Active;
    logic        Block_Gap_Event;
    logic        Transfer_Complete;
    logic        Aborted;
`ifdef DMA_BOUNDARY_EN
    logic        Addr_Load = 1'b0;
    logic        Dma_Int;
`endif

    always #5 CLK = ~CLK;

    dma_transfer_ctrl dut (
        .CLK                        (CLK),
        .RESET                      (RESET),
        .Start                      (Start),
        .System_Address             (System_Address),
        .Block_Size_Register        (Block_Size_Register),
        .Block_Count_Register       (Block_Count_Register),
        .Transfer_Mode_Register     (Transfer_Mode_Register),
        .Block_Gap_Control_Register (Block_Gap_Control_Register),
        .Command_Register           (Command_Register),
        .Fifo_Ready                 (Fifo_Ready),
        .Mem_Req                    (Mem_Req),
        .Mem_Ack                    (Mem_Ack),
        .Mem_Addr                   (Mem_Addr),
        .Mem_Write                  (Mem_Write),
        .Mem_Bytes                  (Mem_Bytes),
        .Blocks_Left                (Blocks_Left),
        .Read_Transfer_Active       (Read_Transfer_Active),
        .Write_Transfer_Active      (Write_Transfer_Active),
        .Block_Gap_Event            (Block_Gap_Event),
        .Transfer_Complete          (Transfer_Complete),
        .Aborted                    (Aborted)
`ifdef DMA_BOUNDARY_EN
        ,
        .Addr_Load                  (Addr_Load),
        .Dma_Int                    (Dma_Int)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  bytes;
        logic        wr;
        logic [15:0] bl;
    } beat_t;

    typedef struct {
        logic        aborted;
        logic        dir;
        logic [15:0] bl;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks    = 0;
    int errors    = 0;
    int gap_count = 0;
    int ack_fixed = -1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected beats from byte/block arithmetic; addresses advance a
    // full beat width per beat, blocks back to back.
    task automatic model_xfer(input logic [31:0] a, input int bs,
                              input int bc, input logic [15:0] tm);
        int    nblk;
        int    n;
        int    rem;
        beat_t b;
        done_t d;
        nblk      = tm[5] ? bc : 1;
        n         = 0;
        d.aborted = 1'b0;
        d.dir     = tm[4];
        if (bs == 0 || nblk == 0) begin
            d.bl = 16'(nblk);
            done_q.push_back(d);
            return;
        end
        for (int k = 0; k < nblk; k++) begin
            rem = bs;
            while (rem > 0) begin
                b.addr  = a + 32'(n * BPB);
                b.bytes = 3'(rem < BPB ? rem : BPB);
                b.wr    = tm[4];
                b.bl    = 16'(nblk - k);
                beat_q.push_back(b);
                rem -= BPB;
                n++;
            end
        end
        d.bl = 16'd0;
        done_q.push_back(d);
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input int bs,
                              input int bc, input logic [15:0] tm,
                              input logic [7:0] bgc);
        @(posedge CLK);
        #1;
        System_Address             = a;
        Block_Size_Register        = 16'(bs);
        Block_Count_Register       = 16'(bc);
        Transfer_Mode_Register     = tm;
        Block_Gap_Control_Register = bgc;
        Start                      = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (beat_q.size() == 0 && done_q.size() == 0) break;
            @(posedge CLK);
        end
        if (i == 3000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout beats_pending=%0d dones_pending=%0d required=0",
                     tag, beat_q.size(), done_q.size());
            beat_q.delete();
            done_q.delete();
            apply_reset();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int i;
        for (i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (Mem_Req) break;
        end
        if (i == 500) begin
            checks++;
            errors++;
            $display("FAIL %s no Mem_Req actual=0 required=1", tag);
        end
    endtask

    // Memory responder: random acknowledge latency unless pinned.
    initial begin
        int wc;
        int dly;
        wc      = 0;
        dly     = 0;
        Mem_Ack = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (Mem_Ack) begin
                Mem_Ack = 1'b0;
                wc      = 0;
            end else if (Mem_Req && !RESET) begin
                if (wc == 0) dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                if (wc >= dly) Mem_Ack = 1'b1;
                else wc++;
            end else begin
                wc = 0;
            end
        end
    end

    initial begin
        Fifo_Ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1 Fifo_Ready = $urandom_range(0, 99) < 75;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or end.
    initial begin
        logic        pr;
        logic        pa;
        logic [31:0] paddr;
        logic [2:0]  pbytes;
        beat_t       e;
        done_t       d;
        pr     = 1'b0;
        pa     = 1'b0;
        paddr  = '0;
        pbytes = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                pr = 1'b0;
                pa = 1'b0;
            end else begin
                if (pr && !pa) begin
                    chk("req_hold", {Mem_Req, Mem_Addr, Mem_Bytes},
                        {1'b1, paddr, pbytes});
                end
                if (Mem_Req && Mem_Ack) begin
                    if (beat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected addr=%0h required=none", Mem_Addr);
                    end else begin
                        e = beat_q.pop_front();
                        chk("beat_addr", Mem_Addr, e.addr);
                        chk("beat_bytes", Mem_Bytes, e.bytes);
                        chk("beat_write", Mem_Write, e.wr);
                        chk("beat_blocks_left", Blocks_Left, e.bl);
                        chk("beat_active", {Read_Transfer_Active, Write_Transfer_Active},
                            {e.wr, !e.wr});
                    end
                end
                if (Block_Gap_Event) gap_count++;
                if (Transfer_Complete) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL complete_unexpected actual=1 required=0");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_aborted", Aborted, d.aborted);
                        chk("done_active", {Read_Transfer_Active, Write_Transfer_Active},
                            {d.dir, !d.dir});
                        chk("done_blocks_left", Blocks_Left, d.bl);
                        chk("done_beats_drained", beat_q.size(), 0);
                    end
                end else if (Aborted) begin
                    checks++;
                    errors++;
                    $display("FAIL aborted_without_complete actual=1 required=0");
                end
                pr     = Mem_Req;
                pa     = Mem_Ack;
                paddr  = Mem_Addr;
                pbytes = Mem_Bytes;
            end
        end
    end

    initial begin
        int      reqs;
        int      i;
        int      g0;
        int      bs;
        int      bc;
        logic    multi;
        logic    dir;
        logic [15:0] tm;
        logic [31:0] a;
        done_t   d;
        beat_t   b;

        Start                      = 1'b0;
        System_Address             = '0;
        Block_Size_Register        = '0;
        Block_Count_Register       = '0;
        Transfer_Mode_Register     = '0;
        Block_Gap_Control_Register = '0;
        Command_Register           = '0;
        apply_reset();
        chk("reset_outputs",
            {Mem_Req, Mem_Addr, Mem_Write, Mem_Bytes, Blocks_Left,
             Read_Transfer_Active, Write_Transfer_Active, Block_Gap_Event,
             Transfer_Complete, Aborted}, 64'd0);

        // Single block, card to memory, two full beats.
        model_xfer(32'h1000, 8, 1, 16'h0011);
        start_xfer(32'h1000, 8, 1, 16'h0011, 8'h00);
        wait_done("t1");

        // Counted multi-block read from memory; a stray Start is ignored.
        model_xfer(32'h2000, 4, 3, 16'h0023);
        start_xfer(32'h2000, 4, 3, 16'h0023, 8'h00);
        repeat (2) @(posedge CLK);
        #1 System_Address = 32'h9000;
        Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        wait_done("t2");
        chk("t2_final_blocks_left", Blocks_Left, 16'd0);

        // Partial last beat.
        model_xfer(32'h1000, 6, 1, 16'h0001);
        start_xfer(32'h1000, 6, 1, 16'h0001, 8'h00);
        wait_done("t3");

        // Stop at block gap, then continue.
        g0 = gap_count;
        model_xfer(32'h3000, 8, 2, 16'h0033);
        start_xfer(32'h3000, 8, 2, 16'h0033, 8'h01);
        for (i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (gap_count > g0) break;
        end
        chk("gap_event_seen", gap_count, g0 + 1);
        reqs = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Mem_Req) reqs++;
        end
        chk("gap_no_req", reqs, 0);
        chk("gap_blocks_left", Blocks_Left, 16'd1);
        @(posedge CLK);
        #1 Block_Gap_Control_Register = 8'h02;
        wait_done("t4");
        Block_Gap_Control_Register = 8'h00;
        chk("gap_single_event", gap_count, g0 + 1);

        // Abort during a slow acknowledge: the beat finishes first.
        ack_fixed = 5;
        b.addr = 32'h4000;
        b.bytes = 3'd4;
        b.wr = 1'b0;
        b.bl = 16'd1;
        beat_q.push_back(b);
        d.aborted = 1'b1;
        d.dir = 1'b0;
        d.bl = 16'd1;
        done_q.push_back(d);
        start_xfer(32'h4000, 16, 1, 16'h0001, 8'h00);
        wait_req("t5");
        Command_Register = 16'h00C0;
        wait_done("t5");
        Command_Register = 16'h0000;
        ack_fixed = -1;
        chk("abort_idle", {Read_Transfer_Active, Write_Transfer_Active, Mem_Req}, 0);

        // Reset in the middle of a beat, then a clean transfer.
        ack_fixed = 10;
        start_xfer(32'h5000, 32, 1, 16'h0011, 8'h00);
        wait_req("t6");
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("midreset_outputs",
            {Mem_Req, Mem_Addr, Mem_Write, Mem_Bytes, Blocks_Left,
             Read_Transfer_Active, Write_Transfer_Active, Block_Gap_Event,
             Transfer_Complete, Aborted}, 64'd0);
        RESET = 1'b0;
        beat_q.delete();
        done_q.delete();
        ack_fixed = -1;
        model_xfer(32'h6000, 12, 1, 16'h0011);
        start_xfer(32'h6000, 12, 1, 16'h0011, 8'h00);
        wait_done("t6b");

        // DMA disabled: Start does nothing.
        start_xfer(32'h7000, 8, 1, 16'h0010, 8'h00);
        reqs = 0;
        repeat (10) begin
            @(negedge CLK);
            if (Mem_Req || Transfer_Complete) reqs++;
        end
        chk("dma_disabled_idle", {reqs, Read_Transfer_Active, Write_Transfer_Active}, 0);

        // Zero-length transfers complete without bus traffic.
        model_xfer(32'h8000, 0, 2, 16'h0023);
        start_xfer(32'h8000, 0, 2, 16'h0023, 8'h00);
        wait_done("zero_bs");
        model_xfer(32'h8000, 8, 0, 16'h0033);
        start_xfer(32'h8000, 8, 0, 16'h0033, 8'h00);
        wait_done("zero_bc");

        for (int n = 0; n < 25; n++) begin
            bs    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4))
                                                : int'($urandom_range(1, 40));
            bc    = int'($urandom_range(0, 4));
            multi = 1'($urandom_range(0, 1));
            dir   = 1'($urandom_range(0, 1));
            tm    = 16'h0001 | (dir ? 16'h0010 : 16'h0000) |
                    (multi ? 16'h0022 : 16'h0000);
            a     = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2);
            model_xfer(a, bs, bc, tm);
            start_xfer(a, bs, bc, tm, 8'h00);
            wait_done("random");
        end

        chk("gap_total", gap_count, g0 + 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
